// File: rtl/bcrypt_pkg.sv
// bcrypt_pkg: shared constants, state encoding and salt word selection for the ExpandState sequencer
package bcrypt_pkg;

    localparam int NUM_P        = 18;
    localparam int S_ENTRIES    = 256;
    localparam int NUM_S        = 4;
    localparam int P_BLOCKS     = NUM_P / 2;
    localparam int TOTAL_BLOCKS = P_BLOCKS + NUM_S * S_ENTRIES / 2;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t LOAD = 3'd1;
    localparam state_t RUN  = 3'd2;
    localparam state_t WR0  = 3'd3;
    localparam state_t WR1  = 3'd4;
    localparam state_t FIN  = 3'd5;

    // Word 0 is the most significant 32 bits of the salt.
    function automatic logic [31:0] salt_word(input logic [127:0] salt, input logic [1:0] idx);
        logic [1:0] k;
        k = ~idx;
        return salt[{k, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/block_addr_gen.sv
// block_addr_gen: maps a block index and word half to the P or S-box write slot
module block_addr_gen
    import bcrypt_pkg::*;
(
    input  logic [9:0] blk,
    input  logic       half,
    output logic       is_p,
    output logic [1:0] s_box,
    output logic [7:0] addr
);

    logic [8:0] off;

    assign off   = 9'(blk - 10'(P_BLOCKS));
    assign is_p  = blk < 10'(P_BLOCKS);
    assign s_box = is_p ? 2'd0 : off[8:7];
    assign addr  = is_p ? {blk[6:0], half} : {off[6:0], half};

endmodule

// File: rtl/expand_state_ctrl.sv
// expand_state_ctrl: sequences the 521 chained feistel encryptions of ExpandState into the P and S arrays
module expand_state_ctrl
    import bcrypt_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         use_salt,
    input  logic [127:0] salt,
    output logic         f_start,
    output logic [31:0]  f_L,
    output logic [31:0]  f_R,
    input  logic [31:0]  f_resultL,
    input  logic [31:0]  f_resultR,
    input  logic         f_done,
    output logic         own_sram,
    output logic         p_cs_l,
    output logic         p_we_l,
    output logic [7:0]   p_addr,
    output logic [31:0]  p_in,
    output logic [3:0]   s_cs_l,
    output logic [3:0]   s_we_l,
    output logic [7:0]   s_addr,
    output logic [31:0]  s_in,
    output logic         busy,
    output logic         done
);

    state_t      state;
    logic [9:0]  blk;
    logic [31:0] c_l, c_r;
    logic        salt_en;
    logic        wr, half, is_p, p_wr, s_wr;
    logic [1:0]  s_box;
    logic [7:0]  addr;
    logic [31:0] wdata, salt_l, salt_r;

    assign wr    = (state == WR0) || (state == WR1);
    assign half  = state == WR1;
    assign p_wr  = wr && is_p;
    assign s_wr  = wr && !is_p;
    assign wdata = half ? c_r : c_l;

    block_addr_gen u_addr (
        .blk   (blk),
        .half  (half),
        .is_p  (is_p),
        .s_box (s_box),
        .addr  (addr)
    );

    // Pass sequencing: block counter, result chaining and state transitions
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            blk     <= '0;
            c_l     <= '0;
            c_r     <= '0;
            salt_en <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= LOAD;
                    blk     <= '0;
                    c_l     <= '0;
                    c_r     <= '0;
                    salt_en <= use_salt;
                end
                LOAD: state <= RUN;
                RUN: if (f_done) begin
                    c_l   <= f_resultL;
                    c_r   <= f_resultR;
                    state <= WR0;
                end
                WR0: state <= WR1;
                WR1: if (blk == 10'(TOTAL_BLOCKS - 1)) state <= FIN;
                     else begin
                         blk   <= blk + 10'd1;
                         state <= LOAD;
                     end
                default: state <= IDLE;
            endcase
        end
    end

    // Even blocks mix salt words 0/1, odd blocks words 2/3
    assign salt_l = salt_en ? salt_word(salt, {blk[0], 1'b0}) : 32'd0;
    assign salt_r = salt_en ? salt_word(salt, {blk[0], 1'b1}) : 32'd0;

    assign f_start  = state == LOAD;
    assign f_L      = f_start ? c_l ^ salt_l : 32'd0;
    assign f_R      = f_start ? c_r ^ salt_r : 32'd0;
    assign own_sram = wr;
    assign p_cs_l   = !p_wr;
    assign p_we_l   = !p_wr;
    assign p_addr   = p_wr ? addr : 8'd0;
    assign p_in     = p_wr ? wdata : 32'd0;
    assign s_cs_l   = s_wr ? ~(4'b0001 << s_box) : 4'hF;
    assign s_we_l   = s_cs_l;
    assign s_addr   = s_wr ? addr : 8'd0;
    assign s_in     = s_wr ? wdata : 32'd0;
    assign busy     = state != IDLE;
    assign done     = state == FIN;

endmodule

// File: tb/tb_expand_state_ctrl.sv
// tb_expand_state_ctrl: scoreboard bench with a 3-cycle feistel stub for the ExpandState sequencer
module tb_expand_state_ctrl;

    logic         clk = 1'b0;
    logic         reset, start, use_salt, spur;
    logic [127:0] salt;
    logic         f_start, f_done, own_sram, p_cs_l, p_we_l, busy, done;
    logic [31:0]  f_L, f_R, p_in, s_in;
    logic [31:0]  res_l, res_r;
    logic [7:0]   p_addr, s_addr;
    logic [3:0]   s_cs_l, s_we_l;
    logic [1:0]   cnt;

    int checks = 0;
    int errors = 0;
    int n_start, n_p, n_done;
    int n_s [4];

    logic [63:0] sq [$];
    logic [44:0] wq [$];
    logic [63:0] slog [$];
    logic [44:0] wlog [$];

    always #5 clk = ~clk;

    expand_state_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .use_salt  (use_salt),
        .salt      (salt),
        .f_start   (f_start),
        .f_L       (f_L),
        .f_R       (f_R),
        .f_resultL (res_l),
        .f_resultR (res_r),
        .f_done    (f_done),
        .own_sram  (own_sram),
        .p_cs_l    (p_cs_l),
        .p_we_l    (p_we_l),
        .p_addr    (p_addr),
        .p_in      (p_in),
        .s_cs_l    (s_cs_l),
        .s_we_l    (s_we_l),
        .s_addr    (s_addr),
        .s_in      (s_in),
        .busy      (busy),
        .done      (done)
    );

    // Feistel stub: result {L+1, ~R}, done pulse three cycles after start
    always @(posedge clk) begin
        if (reset) cnt <= 2'd0;
        else if (f_start) begin
            cnt   <= 2'd3;
            res_l <= f_L + 32'd1;
            res_r <= ~f_R;
        end else if (cnt != 2'd0) cnt <= cnt - 2'd1;
    end

    assign f_done = (cnt == 2'd1) | spur;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: expected feistel inputs and write tuples {p_cs_l, s_cs_l, addr, data}
    task automatic gen_pass(input logic us, input logic [127:0] sl);
        logic [31:0] cl, cr, l, r, wl, wr_;
        int b, j;
        cl = 0;
        cr = 0;
        sq.delete();
        wq.delete();
        for (int k = 0; k < 521; k++) begin
            wl  = 32'(sl >> (32 * (3 - ((2 * k) % 4))));
            wr_ = 32'(sl >> (32 * (3 - ((2 * k + 1) % 4))));
            l = us ? cl ^ wl : cl;
            r = us ? cr ^ wr_ : cr;
            sq.push_back({l, r});
            cl = l + 1;
            cr = ~r;
            if (k < 9) begin
                wq.push_back({1'b0, 4'hF, 8'(2 * k), cl});
                wq.push_back({1'b0, 4'hF, 8'(2 * k + 1), cr});
            end else begin
                b = (k - 9) / 128;
                j = (k - 9) % 128;
                wq.push_back({1'b1, ~(4'b0001 << b), 8'(2 * j), cl});
                wq.push_back({1'b1, ~(4'b0001 << b), 8'(2 * j + 1), cr});
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a start or a write
    always @(negedge clk) begin
        logic [63:0] e;
        logic [44:0] w, ew;
        if (f_start) begin
            n_start++;
            slog.push_back({f_L, f_R});
            if (sq.size() == 0) chk("extra_start", 64'(sq.size()), 64'd1);
            else begin
                e = sq.pop_front();
                chk("f_LR", {f_L, f_R}, e);
            end
        end
        if (!p_cs_l || s_cs_l != 4'hF) begin
            w = {p_cs_l, s_cs_l, p_cs_l ? s_addr : p_addr, p_cs_l ? s_in : p_in};
            wlog.push_back(w);
            chk("we_eq_cs", {59'd0, p_we_l, s_we_l}, {59'd0, p_cs_l, s_cs_l});
            chk("own_sram", 64'(own_sram), 64'd1);
            if (!p_cs_l) n_p++;
            for (int b = 0; b < 4; b++) if (!s_cs_l[b]) n_s[b]++;
            if (wq.size() == 0) chk("extra_write", 64'(wq.size()), 64'd1);
            else begin
                ew = wq.pop_front();
                chk("write", 64'(w), 64'(ew));
            end
        end
        if (done) n_done++;
    end

    task automatic clear_logs();
        n_start = 0;
        n_p = 0;
        n_done = 0;
        for (int b = 0; b < 4; b++) n_s[b] = 0;
        slog.delete();
        wlog.delete();
    endtask

    task automatic kick(input logic us, input logic [127:0] sl);
        @(negedge clk);
        use_salt = us;
        salt = sl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        use_salt = 1'b0;
    endtask

    task automatic wait_run(input int blk_starts, input logic [1:0] c, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = (n_start >= blk_starts) && (cnt == c);
        end
    endtask

    task automatic run_pass(input logic us, input logic [127:0] sl, input logic disturb);
        logic ok;
        gen_pass(us, sl);
        clear_logs();
        kick(us, sl);
        if (disturb) begin
            wait_run(6, 2'd3, ok);
            chk("reach_run", 64'(ok), 64'd1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_run(6, 2'd1, ok);
            @(negedge clk);
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        chk("done_seen", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("n_done", 64'(n_done), 64'd1);
        chk("n_start", 64'(n_start), 64'd521);
        chk("n_p", 64'(n_p), 64'd18);
        for (int b = 0; b < 4; b++) chk("n_s", 64'(n_s[b]), 64'd256);
        chk("sq_left", 64'(sq.size()), 64'd0);
        chk("wq_left", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        logic ok;
        reset = 1'b1;
        start = 1'b0;
        use_salt = 1'b0;
        salt = '0;
        spur = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fstart", 64'(f_start), 64'd0);
        chk("rst_own", 64'(own_sram), 64'd0);
        chk("rst_strobes", {54'd0, p_cs_l, p_we_l, s_cs_l, s_we_l}, 64'h3FF);
        chk("rst_data", {p_addr, s_addr, p_in ^ s_in}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", 64'(busy), 64'd0);

        run_pass(1'b0, '0, 1'b0);
        chk("blk0_LR", slog[0], 64'd0);
        chk("blk1_LR", slog[1], {32'h1, 32'hFFFF_FFFF});
        chk("P0", 64'(wlog[0]), 64'({1'b0, 4'hF, 8'd0, 32'h1}));
        chk("P1", 64'(wlog[1]), 64'({1'b0, 4'hF, 8'd1, 32'hFFFF_FFFF}));
        chk("P16", 64'(wlog[16][44:32]), 64'({1'b0, 4'hF, 8'd16}));
        chk("P17", 64'(wlog[17][44:32]), 64'({1'b0, 4'hF, 8'd17}));
        chk("S1_0", 64'(wlog[18][44:32]), 64'({1'b1, 4'b1110, 8'd0}));
        chk("S1_1", 64'(wlog[19][44:32]), 64'({1'b1, 4'b1110, 8'd1}));
        chk("S2_0", 64'(wlog[274][44:32]), 64'({1'b1, 4'b1101, 8'd0}));
        chk("S4_255", 64'(wlog[1041][44:32]), 64'({1'b1, 4'b0111, 8'd255}));

        run_pass(1'b1, 128'h00000001_00000002_00000003_00000004, 1'b1);
        chk("salt_blk0", slog[0], {32'h1, 32'h2});
        chk("salt_blk1", slog[1], {32'h1, 32'hFFFF_FFF9});

        gen_pass(1'b0, '0);
        clear_logs();
        kick(1'b0, '0);
        wait_run(51, 2'd1, ok);
        chk("reach_blk50", 64'(ok), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_strobes", {55'd0, own_sram, p_cs_l, p_we_l, s_cs_l, s_we_l}, 64'h3FF);
        chk("rr_fstart", 64'(f_start), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rr_idle", 64'(busy), 64'd0);
        run_pass(1'b0, '0, 1'b0);
        chk("replay_blk0", slog[0], 64'd0);
        chk("replay_blk1", slog[1], {32'h1, 32'hFFFF_FFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
